ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Receives the raw PS/2 keyboard serial stream (device-to-host) and turns it into
//  the 11-bit ps2_key event word used by the core input logic:
//  {toggle, pressed, extended, code[7:0]}. The core detects a new event from the toggle
//  bit and decodes keys with casex on code[8:0]. Sits between the board PS/2 pins and emu.
// PARAMETERS
//  FILTER_LEN  8      clk_sys cycles a synced ps2_clk level must hold before it is accepted
//  TIMEOUT     50000  clk_sys cycles with no filtered clock edge that abort a frame (~2 ms @24 MHz)
// PORTS
//  clk_sys   in   1   system clock; all logic is on the rising edge
//  reset_n   in   1   asynchronous, active-low reset
//  ps2_clk   in   1   raw PS/2 clock pin, asynchronous to clk_sys
//  ps2_data  in   1   raw PS/2 data pin, asynchronous to clk_sys
//  ps2_key   out  11  [10] toggle, [9] pressed, [8] extended (E0), [7:0] scan code
//  key_valid out  1   one-cycle pulse in the cycle ps2_key changes
//  frame_err out  1   one-cycle pulse when a frame is dropped (start, parity, stop or timeout error)
// BEHAVIOUR
//  Reset: ps2_key=0, key_valid=0, frame_err=0; FSM=IDLE; ext/rel flags clear; skip count=0.
//  Input conditioning: both pins pass through 2-FF synchronisers.
//  Filtered clock: a level change is accepted only after the synced level has held
//   FILTER_LEN consecutive cycles. fall = one-cycle pulse on a filtered 1->0 transition.
//  Data is sampled (synced ps2_data) in the fall cycle.
//  FSM:
//   IDLE : on fall -> store bit0 (start), bitcnt=1, go to RECV.
//   RECV : on fall -> shift the bit in; bits 1-8 are data LSB-first, bit 9 is parity,
//          bit 10 is stop. After bit 10 -> CHECK. Timeout counter is cleared on every fall.
//          If the counter reaches TIMEOUT -> frame_err pulse, clear ext/rel, go to IDLE.
//   CHECK: one cycle. Frame is valid iff start==0, stop==1 and ^{data,parity}==1 (odd).
//          Invalid frame -> frame_err pulse, clear ext/rel, no event.
//          Valid frame, in priority order:
//            skip>0 -> skip-=1, byte discarded.
//            E1     -> skip=7 (Pause sequence discarded), clear ext/rel.
//            E0     -> ext=1.
//            F0     -> rel=1.
//            other  -> ps2_key <= {~ps2_key[10], ~rel, ext, byte}; key_valid=1; clear ext/rel.
//          Always returns to IDLE.
//  Latency: ps2_key/key_valid are updated 2 clk_sys cycles after the fall that samples the
//   stop bit (fall cycle N, CHECK cycle N+1, visible at N+2).
//  The toggle bit flips exactly once per emitted event. Prefix bytes, skipped bytes and
//   errors never flip it.
//  The timeout counter saturates at TIMEOUT and does not run in IDLE. Its width is $clog2(TIMEOUT+1).
//  A filtered clock glitch shorter than FILTER_LEN cycles produces no fall and no sampled bit.
//  Asserting reset_n low mid-frame: every register returns to its reset value immediately.
//   The partial frame is lost and no key_valid or frame_err pulse is produced.
//  The receiver never drives the pins (no inhibit, no host-to-device transmit).
// TESTING
//  Make 1C ('A'), good parity -> ps2_key=11'h61C (toggle 1, pressed 1, ext 0);
//   key_valid high for 1 cycle at N+2.
//  F0 then 1C -> exactly one event, ps2_key=11'h01C (toggle 0, pressed 0); no event after the F0 byte.
//  E0 75 then E0 F0 75 -> ps2_key=11'h775, then 11'h175; the toggle bit alternates.
//  Byte 29 with a flipped parity bit -> frame_err pulse, ps2_key unchanged;
//   a following good 29 -> ps2_key[8:0]=9'h029.
//  Stop after 5 bits and idle for TIMEOUT+10 cycles -> one frame_err pulse, FSM back in IDLE;
//   the next full frame decodes correctly.
//  E1 14 77 E1 F0 14 F0 77 then 05 -> only the 05 event is emitted.
//   A 3-cycle ps2_clk glitch mid-frame shifts no bit.
//   Pulsing reset_n low mid-frame -> ps2_key=0 and no pulses.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises and filters the raw pins, deframes
// 11-bit device-to-host frames and folds E0/F0/E1 prefixes into the 11-bit
// event word {toggle, pressed, extended, code[7:0]}.
//
// Handshake: there is no backpressure. key_valid is a one-cycle strobe that
// marks the cycle in which ps2_key takes a new value; frame_err is a
// one-cycle strobe for every dropped frame. Consumers may also detect new
// events purely from ps2_key[10] flipping.
module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_valid,
  output logic        frame_err,
  output logic [1:0]  dbg_state
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t state_q, state_d;

  // synchroniser and filter state
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  // frame assembly
  logic [10:0]   frame;
  logic [3:0]    bitcnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    frame_byte;
  logic          frame_ok;

  // prefix tracking
  logic          ext_q, rel_q;
  logic [2:0]    skip_q;

  // per-cycle decisions from the FSM
  logic          start_en, shift_en;
  logic          tmo_clr, tmo_inc;
  logic          flags_clr, ext_set, rel_set;
  logic          skip_load, skip_dec;
  logic          emit_d, err_d;

  // Two-flop synchronisers; both pins idle high on the bus.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: the accepted clock level follows the synced level only
  // after it has differed for FILTER_LEN consecutive cycles.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      clk_filt <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // The fall strobe is the cycle in which a 1->0 level is accepted.
  assign fall = clk_filt && !clk_s2 && (filt_cnt == FILT_LAST);

  assign frame_byte = frame[8:1];
  assign frame_ok   = !frame[0] && frame[10] && (^frame[9:1]);
  assign dbg_state  = state_q;

  // FSM state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and per-cycle datapath controls.
  always_comb begin
    state_d   = state_q;
    start_en  = 1'b0;
    shift_en  = 1'b0;
    tmo_clr   = 1'b0;
    tmo_inc   = 1'b0;
    flags_clr = 1'b0;
    ext_set   = 1'b0;
    rel_set   = 1'b0;
    skip_load = 1'b0;
    skip_dec  = 1'b0;
    emit_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_clr = 1'b1;
        if (fall) begin
          start_en = 1'b1;
          state_d  = RECV;
        end
      end
      RECV: begin
        if (fall) begin
          shift_en = 1'b1;
          tmo_clr  = 1'b1;
          if (bitcnt == 4'd10) state_d = CHECK;
        end else if (tmo_cnt == TMO_MAX) begin
          // Device stopped clocking mid-frame: drop it.
          err_d     = 1'b1;
          flags_clr = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      CHECK: begin
        tmo_clr = 1'b1;
        state_d = IDLE;
        if (!frame_ok) begin
          err_d     = 1'b1;
          flags_clr = 1'b1;
        end else if (skip_q != 3'd0) begin
          skip_dec = 1'b1;
        end else if (frame_byte == 8'hE1) begin
          // Pause: the remaining seven bytes of the sequence carry no key.
          skip_load = 1'b1;
          flags_clr = 1'b1;
        end else if (frame_byte == 8'hE0) begin
          ext_set = 1'b1;
        end else if (frame_byte == 8'hF0) begin
          rel_set = 1'b1;
        end else begin
          emit_d    = 1'b1;
          flags_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame shift register and bit counter.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      frame  <= '0;
      bitcnt <= '0;
    end else if (start_en) begin
      frame[0] <= dat_s2;
      bitcnt   <= 4'd1;
    end else if (shift_en) begin
      frame[bitcnt] <= dat_s2;
      bitcnt        <= bitcnt + 4'd1;
    end
  end

  // Inter-edge timeout counter; held at zero outside RECV and saturating.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (tmo_clr) begin
      tmo_cnt <= '0;
    end else if (tmo_inc) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Prefix flags and Pause skip counter.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ext_q  <= 1'b0;
      rel_q  <= 1'b0;
      skip_q <= '0;
    end else begin
      if (flags_clr) begin
        ext_q <= 1'b0;
        rel_q <= 1'b0;
      end else begin
        if (ext_set) ext_q <= 1'b1;
        if (rel_set) rel_q <= 1'b1;
      end
      if (skip_load)     skip_q <= 3'd7;
      else if (skip_dec) skip_q <= skip_q - 3'd1;
    end
  end

  // Event word and output strobes; the toggle bit flips once per event.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_key   <= '0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= emit_d;
      frame_err <= err_d;
      if (emit_d) ps2_key <= {~ps2_key[10], ~rel_q, ext_q, frame_byte};
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: a PS/2 device model drives frames, a scoreboard
// queue holds the expected {frame_err, ps2_key} of every strobe.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int FILT = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 20;
  localparam int GAP  = 60;

  // clock / reset
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic key_valid, frame_err;
  logic [1:0] dbg_state;

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT(TMO)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .key_valid (key_valid),
    .frame_err (frame_err),
    .dbg_state (dbg_state)
  );

  // scoreboard
  logic [11:0] exp_q[$];
  logic [11:0] sb_exp;
  int n_vec = 0;
  int n_err = 0;
  int kv_cyc = -1;
  int fall_cyc = -1;

  always @(negedge clk_sys) begin
    if (key_valid || frame_err) begin
      if (key_valid) kv_cyc = cyc;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: key_valid=%0b frame_err=%0b ps2_key=%h, required no strobe",
                 key_valid, frame_err, ps2_key);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({frame_err, ps2_key} !== sb_exp)
          $display("FAIL strobe: got err=%0b key=%h, required err=%0b key=%h",
                   frame_err, ps2_key, sb_exp[11], sb_exp[10:0]);
        if ({frame_err, ps2_key} !== sb_exp) n_err++;
      end
    end
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(5);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(HALF - 8);
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk  = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par,
                            input int nbits = 11, input int glitch_at = -1);
    logic [10:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = code;
    bits[9]   = (~^code) ^ bad_par;
    bits[10]  = 1'b1;
    for (int i = 0; i < nbits; i++) send_bit(bits[i], i == glitch_at);
    wait_cyc(GAP);
  endtask

  typedef struct {
    logic [7:0]  code;
    logic        bad_par;
    logic        exp_evt;
    logic        exp_err;
    logic [10:0] exp_key;
  } vec_t;

  vec_t vecs[19];
  logic [10:0] cur_key;

  initial begin
    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 11'h61C};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 11'h000};
    vecs[2]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 11'h01C};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 11'h000};
    vecs[4]  = '{8'h75, 1'b0, 1'b1, 1'b0, 11'h775};
    vecs[5]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 11'h000};
    vecs[6]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 11'h000};
    vecs[7]  = '{8'h75, 1'b0, 1'b1, 1'b0, 11'h175};
    vecs[8]  = '{8'h29, 1'b1, 1'b0, 1'b1, 11'h175};
    vecs[9]  = '{8'h29, 1'b0, 1'b1, 1'b0, 11'h629};
    vecs[10] = '{8'hE1, 1'b0, 1'b0, 1'b0, 11'h000};
    vecs[11] = '{8'h14, 1'b0, 1'b0, 1'b0, 11'h000};
    vecs[12] = '{8'h77, 1'b0, 1'b0, 1'b0, 11'h000};
    vecs[13] = '{8'hE1, 1'b0, 1'b0, 1'b0, 11'h000};
    vecs[14] = '{8'hF0, 1'b0, 1'b0, 1'b0, 11'h000};
    vecs[15] = '{8'h14, 1'b0, 1'b0, 1'b0, 11'h000};
    vecs[16] = '{8'hF0, 1'b0, 1'b0, 1'b0, 11'h000};
    vecs[17] = '{8'h77, 1'b0, 1'b0, 1'b0, 11'h000};
    vecs[18] = '{8'h05, 1'b0, 1'b1, 1'b0, 11'h205};
    cur_key = 11'h000;

    // reset state
    wait_cyc(4);
    check("reset_key", 12'(ps2_key), 12'h000);
    check("reset_valid", 12'(key_valid), 12'h000);
    check("reset_err", 12'(frame_err), 12'h000);
    check("reset_state", 12'(dbg_state), 12'h000);
    reset_n = 1'b1;
    wait_cyc(4);

    // table-driven byte stream
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].exp_evt) begin
        exp_q.push_back({1'b0, vecs[i].exp_key});
        cur_key = vecs[i].exp_key;
      end
      if (vecs[i].exp_err) exp_q.push_back({1'b1, cur_key});
      send_frame(vecs[i].code, vecs[i].bad_par);
      check($sformatf("drain_%0d", i), 12'(exp_q.size()), 12'h000);
      check($sformatf("hold_%0d", i), 12'(ps2_key), 12'(cur_key));
      // 2 sync + FILTER_LEN filter cycles to the fall strobe, then N+2.
      if (i == 0) check("latency", 12'(kv_cyc - fall_cyc), 12'(FILT + 3));
    end

    // timeout after 5 bits
    exp_q.push_back({1'b1, cur_key});
    send_frame(8'h3C, 1'b0, 5);
    check("tmo_early", 12'(exp_q.size()), 12'h001);
    wait_cyc(TMO + 10);
    check("tmo_drain", 12'(exp_q.size()), 12'h000);
    check("tmo_idle", 12'(dbg_state), 12'h000);
    exp_q.push_back({1'b0, 11'h61C});
    send_frame(8'h1C, 1'b0);
    check("tmo_next", 12'(exp_q.size()), 12'h000);

    // short clock glitch inside a frame
    exp_q.push_back({1'b0, 11'h25A});
    send_frame(8'h5A, 1'b0, 11, 4);
    check("glitch_drain", 12'(exp_q.size()), 12'h000);
    check("glitch_key", 12'(ps2_key), 12'h25A);

    // reset mid-frame
    send_frame(8'h33, 1'b0, 4);
    reset_n = 1'b0;
    wait_cyc(1);
    check("midrst_key", 12'(ps2_key), 12'h000);
    check("midrst_state", 12'(dbg_state), 12'h000);
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(100);
    check("midrst_quiet", 12'(exp_q.size()), 12'h000);
    exp_q.push_back({1'b0, 11'h61C});
    send_frame(8'h1C, 1'b0);
    check("midrst_next", 12'(exp_q.size()), 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
